// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl -- read-side controller for an asynchronous FIFO.
//
// Owns the binary read counter and drives the RAM read address. It publishes a
// registered Gray read pointer to the write domain and presents data through a
// one-word registered output stage with valid/ready handshaking.
//
// Build option: define FIFO_RD_PTR_CHECK_EN to enable the sticky pointer
// consistency check on r_err. Without it, r_err is tied to 0 and no check
// logic is built.
//
// Parameters:
//   address_width  FIFO depth is 2**address_width words
//   data_width     word width
//   ae_thresh      almost-empty threshold in words
//
// Ports:
//   r_clk           read clock; all state changes on its rising edge
//   rrst_n          asynchronous active-low reset
//   rq2_wptr        Gray write pointer, already synchronized into r_clk
//   mem_rdata       RAM read data at raddr (combinational)
//   r_ready         consumer accepts r_data this cycle
//   r_valid         r_data holds a valid word
//   r_data          registered output word
//   raddr           RAM read address (low bits of the binary read counter)
//   rptr            registered Gray read pointer for the write domain
//   rempty          registered pointer-level empty flag
//   r_level         words in RAM not yet fetched (combinational)
//   r_almost_empty  r_level <= ae_thresh
//   r_err           sticky pointer-consistency error
module fifo_rd_ctrl #(
  parameter int unsigned address_width = 3,
  parameter int unsigned data_width    = 8,
  parameter int unsigned ae_thresh     = 1
) (
  input  logic                     r_clk,
  input  logic                     rrst_n,
  input  logic [address_width:0]   rq2_wptr,
  input  logic [data_width-1:0]    mem_rdata,
  input  logic                     r_ready,
  output logic                     r_valid,
  output logic [data_width-1:0]    r_data,
  output logic [address_width-1:0] raddr,
  output logic [address_width:0]   rptr,
  output logic                     rempty,
  output logic [address_width:0]   r_level,
  output logic                     r_almost_empty,
  output logic                     r_err
);

  localparam int unsigned DEPTH = 1 << address_width;

  logic [address_width:0] rbin;
  logic [address_width:0] rbin_next;
  logic [address_width:0] rgray_next;
  logic [address_width:0] wbin;
  logic                   fetch;

  // Gray-to-binary: bit i is the XOR of all Gray bits from the MSB down to i.
  always_comb begin
    wbin = '0;
    for (int unsigned i = 0; i <= address_width; i++) begin
      wbin[i] = ^(rq2_wptr >> i);
    end
  end

  // A word is fetched whenever RAM is non-empty and the output stage is free
  // or being drained this cycle, which gives one word per cycle when r_ready
  // stays high.
  always_comb begin
    fetch      = !rempty && (!r_valid || r_ready);
    rbin_next  = rbin + {{address_width{1'b0}}, fetch};
    rgray_next = rbin_next ^ (rbin_next >> 1);
  end

  assign raddr          = rbin[address_width-1:0];
  assign r_level        = wbin - rbin;
  assign r_almost_empty = (32'(r_level) <= ae_thresh);

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin    <= '0;
      rptr    <= '0;
      rempty  <= 1'b1;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      rbin   <= rbin_next;
      rptr   <= rgray_next;
      rempty <= (rgray_next == rq2_wptr);
      if (fetch) begin
        r_data  <= mem_rdata;
        r_valid <= 1'b1;
      end else if (r_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef FIFO_RD_PTR_CHECK_EN
  // More than DEPTH outstanding words cannot occur with a consistent write
  // pointer, so the error latches until reset.
  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_err <= 1'b0;
    end else if (32'(r_level) > DEPTH) begin
      r_err <= 1'b1;
    end
  end
`else
  assign r_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int AE    = 1;
  localparam int DEPTH = 8;
  localparam int MOD   = 16;

  logic          r_clk = 1'b0;
  logic          rrst_n;
  logic [AW:0]   rq2_wptr;
  logic [DW-1:0] mem_rdata;
  logic          r_ready;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic [AW:0]   r_level;
  logic          r_almost_empty;
  logic          r_err;

  logic [DW-1:0] mem [DEPTH];
  assign mem_rdata = mem[raddr];

  fifo_rd_ctrl #(
    .address_width(AW),
    .data_width   (DW),
    .ae_thresh    (AE)
  ) dut (
    .r_clk         (r_clk),
    .rrst_n        (rrst_n),
    .rq2_wptr      (rq2_wptr),
    .mem_rdata     (mem_rdata),
    .r_ready       (r_ready),
    .r_valid       (r_valid),
    .r_data        (r_data),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .r_level       (r_level),
    .r_almost_empty(r_almost_empty),
    .r_err         (r_err)
  );

  always #5 r_clk = ~r_clk;

`ifdef FIFO_RD_PTR_CHECK_EN
  localparam logic ERR_EXPECTED = 1'b1;
`else
  localparam logic ERR_EXPECTED = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model in terms of word counts: wr = words written (mod 16),
  // m_rd = words fetched (mod 16), plus the output stage contents.
  int          wr      = 0;
  int          m_rd    = 0;
  bit          m_valid = 0;
  bit          m_empty = 1;
  bit          m_err   = 0;
  logic [7:0]  m_data  = '0;

  function automatic logic [AW:0] to_gray(input int b);
    logic [AW:0] x;
    x = b[AW:0];
    return x ^ (x >> 1);
  endfunction

  function automatic int lvl();
    return (wr - m_rd + MOD) % MOD;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("rptr",           32'(rptr),           32'(to_gray(m_rd)));
    check("raddr",          32'(raddr),          32'(m_rd % DEPTH));
    check("rempty",         32'(rempty),         32'(m_empty));
    check("r_valid",        32'(r_valid),        32'(m_valid));
    check("r_data",         32'(r_data),         32'(m_data));
    check("r_level",        32'(r_level),        32'(lvl()));
    check("r_almost_empty", 32'(r_almost_empty), 32'(lvl() <= AE));
    check("r_err",          32'(r_err),          32'(m_err));
  endtask

  task automatic set_wr(input int w);
    wr       = w % MOD;
    rq2_wptr = to_gray(wr);
  endtask

  // Called at a falling edge with inputs applied; advances one rising edge
  // and compares at the following falling edge.
  task automatic cycle();
    bit f;
    f = !m_empty && (!m_valid || r_ready);
`ifdef FIFO_RD_PTR_CHECK_EN
    if (lvl() > DEPTH) m_err = 1;
`endif
    @(posedge r_clk);
    if (f) begin
      m_data  = mem[m_rd % DEPTH];
      m_valid = 1;
      m_rd    = (m_rd + 1) % MOD;
    end else if (m_valid && r_ready) begin
      m_valid = 0;
    end
    m_empty = (m_rd == wr);
    @(negedge r_clk);
    compare_all();
  endtask

  task automatic do_reset();
    rrst_n  = 1'b0;
    m_rd    = 0;
    m_valid = 0;
    m_empty = 1;
    m_err   = 0;
    m_data  = '0;
    set_wr(0);
    #1;
    compare_all();
    @(negedge r_clk);
    compare_all();
    rrst_n = 1'b1;
  endtask

  initial begin
    rrst_n  = 1'b0;
    r_ready = 1'b0;
    set_wr(0);
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    @(negedge r_clk);
    compare_all();
    // Reset state literals
    check("rst_rptr",   32'(rptr),           32'h0);
    check("rst_raddr",  32'(raddr),          32'h0);
    check("rst_rempty", 32'(rempty),         32'h1);
    check("rst_valid",  32'(r_valid),        32'h0);
    check("rst_data",   32'(r_data),         32'h00);
    check("rst_level",  32'(r_level),        32'h0);
    check("rst_ae",     32'(r_almost_empty), 32'h1);
    rrst_n = 1'b1;

    // Single word with consumer stalled
    mem[0] = 8'hA5;
    set_wr(1);
    r_ready = 1'b0;
    cycle();
    check("single_rempty_lat", 32'(rempty), 32'h0);
    cycle();
    check("single_valid",  32'(r_valid), 32'h1);
    check("single_data",   32'(r_data),  32'hA5);
    check("single_rptr",   32'(rptr),    32'h1);
    check("single_rempty", 32'(rempty),  32'h1);
    check("single_level",  32'(r_level), 32'h0);
    r_ready = 1'b1;
    cycle();
    check("single_drained", 32'(r_valid), 32'h0);

    // Full drain at one word per cycle
    do_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h10 + i);
    set_wr(8);
    r_ready = 1'b1;
    cycle();
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      check("drain_valid", 32'(r_valid), 32'h1);
      check("drain_data",  32'(r_data),  32'(8'h10 + i));
    end
    check("drain_raddr",  32'(raddr),  32'h0);
    check("drain_rptr",   32'(rptr),   32'hC);
    check("drain_rempty", 32'(rempty), 32'h1);

    // Backpressure with three words available
    do_reset();
    mem[0] = 8'h31; mem[1] = 8'h32; mem[2] = 8'h33;
    set_wr(3);
    r_ready = 1'b0;
    cycle();
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_data",  32'(r_data),  32'h31);
      check("bp_raddr", 32'(raddr),   32'h1);
      check("bp_level", 32'(r_level), 32'h2);
    end
    r_ready = 1'b1;
    cycle();
    check("bp_word1", 32'(r_data), 32'h32);
    cycle();
    check("bp_word2", 32'(r_data), 32'h33);
    cycle();

    // Randomized traffic, including pointer wrap and a mid-transfer reset
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      r_ready = ($urandom_range(0, 3) != 0) || (n % 200 < 20 ? 1'b0 : 1'b0);
      if (n % 200 >= 180) r_ready = 1'b0;
      if (lvl() < DEPTH && $urandom_range(0, 2) != 0) begin
        mem[wr % DEPTH] = 8'($urandom);
        set_wr(wr + 1);
      end
      cycle();
    end

    // Pointer consistency: write pointer moves behind the read counter
    do_reset();
    r_ready = 1'b1;
    set_wr(4);
    for (int i = 0; i < 8; i++) cycle();
    check("chk_rd_at_4", 32'(raddr), 32'h4);
    set_wr(1);
    cycle();
    check("chk_err_set", 32'(r_err), 32'(ERR_EXPECTED));
    cycle();
    cycle();
    check("chk_err_held", 32'(r_err), 32'(ERR_EXPECTED));
    do_reset();
    check("chk_err_cleared", 32'(r_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
